dram_access_ctrl: RTL

Two-port access controller for the 64 KB data DRAM (16 KB × 32-bit words, asynchronous read, write on rising clk edge). It arbitrates between the CPU load/store port (port 0) and a debug/DMA port (port 1). Sub-word stores (sb/sh) run as read-modify-write, so neighbouring bytes are preserved. Loads are returned extracted and sign-extended.

---
 rtl/dram_ctrl_pkg.sv | 20 ++
 rtl/dram_lane_unit.sv | 35 +++
 rtl/dram_access_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dram_ctrl_pkg.sv
// rtl/dram_ctrl_pkg.sv - shared types, size codes and alignment check for the DRAM access controller
package dram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b11;

  // The reserved size code is reported the same way as a misaligned access
  function automatic logic misaligned(input logic [1:0] adr, input logic [1:0] sel);
    case (sel)
      SEL_BYTE: return 1'b0;
      SEL_HALF: return adr[0];
      SEL_WORD: return adr != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dram_lane_unit.sv
// rtl/dram_lane_unit.sv - byte/half lane extraction with sign extension and store merge
module dram_lane_unit
  import dram_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  adr,
  input  logic [1:0]  sel,
  input  logic [31:0] wd,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{adr, 3'b000} +: 8];
    half_lane = word[{adr[1], 4'b0000} +: 16];
    load_val  = word;
    merged    = word;
    case (sel)
      SEL_BYTE: begin
        load_val                     = {{24{byte_lane[7]}}, byte_lane};
        merged[{adr, 3'b000} +: 8]   = wd[7:0];
      end
      SEL_HALF: begin
        load_val                     = {{16{half_lane[15]}}, half_lane};
        merged[{adr[1], 4'b0000} +: 16] = wd[15:0];
      end
      SEL_WORD: merged = wd;
      default: ;
    endcase
  end

endmodule

// File: rtl/dram_access_ctrl.sv
// rtl/dram_access_ctrl.sv - two-port round-robin DRAM access controller with sub-word read-modify-write
module dram_access_ctrl
  import dram_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [15:0] p0_adr_i,
  input  logic [31:0] p0_wd_i,
  input  logic [1:0]  p0_sel_i,
  output logic        p0_ack_o,
  output logic        p0_err_o,
  output logic [31:0] p0_rd_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [15:0] p1_adr_i,
  input  logic [31:0] p1_wd_i,
  input  logic [1:0]  p1_sel_i,
  output logic        p1_ack_o,
  output logic        p1_err_o,
  output logic [31:0] p1_rd_o,
  output logic [13:0] ram_adr_o,
  output logic        ram_we_o,
  output logic [31:0] ram_wd_o,
  input  logic [31:0] ram_rd_i
);

  state_t      state;
  logic        gnt, last_gnt, we_q;
  logic [15:0] adr_q;
  logic [31:0] wd_q, mbuf;
  logic [1:0]  sel_q;
  logic [1:0]  ack_q, err_q;
  logic [31:0] rd_q [2];

  logic        any_req, win, req_we;
  logic [15:0] req_adr;
  logic [31:0] req_wd;
  logic [1:0]  req_sel;
  logic [31:0] lane_word, load_val, merged;

  // On a tie the port that did not win last time is granted
  always_comb begin
    any_req = p0_req_i | p1_req_i;
    win     = (p0_req_i & p1_req_i) ? ~last_gnt : p1_req_i;
    req_we  = win ? p1_we_i  : p0_we_i;
    req_adr = win ? p1_adr_i : p0_adr_i;
    req_wd  = win ? p1_wd_i  : p0_wd_i;
    req_sel = win ? p1_sel_i : p0_sel_i;
  end

  assign lane_word = (state == WRITE) ? mbuf : ram_rd_i;

  dram_lane_unit u_lane (
    .word     (lane_word),
    .adr      (adr_q[1:0]),
    .sel      (sel_q),
    .wd       (wd_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // Write strobe depends only on registered state so reset drops it at once
  assign ram_we_o  = (state == WRITE) || (state == ACCESS && we_q && sel_q == SEL_WORD);
  assign ram_adr_o = (state == ACCESS || state == WRITE) ? adr_q[15:2] : 14'd0;
  assign ram_wd_o  = ram_we_o ? merged : 32'd0;

  assign p0_ack_o = ack_q[0];
  assign p1_ack_o = ack_q[1];
  assign p0_err_o = err_q[0];
  assign p1_err_o = err_q[1];
  assign p0_rd_o  = rd_q[0];
  assign p1_rd_o  = rd_q[1];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      sel_q    <= '0;
      mbuf     <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rd_q[0]  <= '0;
      rd_q[1]  <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: if (any_req) begin
          gnt      <= win;
          last_gnt <= win;
          we_q     <= req_we;
          adr_q    <= req_adr;
          wd_q     <= req_wd;
          sel_q    <= req_sel;
          if (misaligned(req_adr[1:0], req_sel)) begin
            ack_q[win] <= 1'b1;
            err_q[win] <= 1'b1;
            rd_q[win]  <= '0;
            state      <= DONE;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rd_q[gnt]  <= load_val;
            ack_q[gnt] <= 1'b1;
            state      <= DONE;
          end else if (sel_q == SEL_WORD) begin
            ack_q[gnt] <= 1'b1;
            state      <= DONE;
          end else begin
            mbuf  <= ram_rd_i;
            state <= WRITE;
          end
        end
        WRITE: begin
          ack_q[gnt] <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
